fifo1_rd_packer: RTL and testbench
==================================

# fifo1_rd_packer

Read-side consumer for the `fifo1` asynchronous FIFO, running entirely in the read clock domain. It drains bytes through the FIFO's `rdata`/`rempty`/`rinc` interface and packs them little-endian into `WBYTES`-wide words. Each word is presented on a valid/ready output port. A `flush` request emits a partial word.

## Interface
Parameters:
- `DSIZE`, 8: FIFO data width, one lane.
- `WBYTES`, 4: lanes per output word, ≥2.

Ports:
- `rclk` in 1: read clock, the single clock of the block.
- `rrst` in 1: reset, synchronous, active-high.
- `rdata` in DSIZE: FIFO read data. Valid whenever `rempty`=0; combinational from the FIFO head.
- `rempty` in 1: FIFO empty flag.
- `rinc` out 1: FIFO pop strobe. One byte is consumed per `rclk` edge where `rinc`=1.
- `flush` in 1: request to emit the partial word, single-cycle or level.
- `out_data` out DSIZE*WBYTES: packed word. Lane 0 is bits [DSIZE-1:0] and holds the first byte read.
- `out_nbytes` out $clog2(WBYTES)+1: number of valid lanes in `out_data`, 1..WBYTES.
- `out_valid` out 1: word available.
- `out_ready` in 1: downstream accepts the word.
- `word_cnt` out 16: count of words transferred.

## Operation
- Two states, FILL and HOLD. A lane index `idx` runs 0..WBYTES-1.
- `rinc` = !rrst && !rempty && (state==FILL || out_ready). This is combinational, and `rinc` is never asserted while `rempty`=1.
- **Pop in FILL:**
  - `rdata` is written to lane `idx`.
  - If `idx`==WBYTES-1: go to HOLD, `out_nbytes`=WBYTES, `idx`=0.
  - Otherwise `idx`+1.
- **Flush in FILL:** if `flush`=1 and (`idx`>0 or a pop occurs this cycle), go to HOLD.
  - `out_nbytes` = `idx` + pop (pop = 1 if a byte is popped this cycle, else 0). The byte popped in the flush cycle is included.
  - `idx` is cleared.
  - `flush` with `idx`=0 and no pop is ignored.
  - A flush coinciding with the pop that completes a word is redundant: a full word is emitted.
- **Unused lanes:** lanes at or above `out_nbytes` read as 0.
- **HOLD:** `out_valid`=1. `out_data` and `out_nbytes` are held stable until `out_ready`=1. `flush` is ignored in HOLD.
- **Transfer (`out_valid` && `out_ready`):**
  - `word_cnt` increments, wrapping 0xFFFF→0x0000.
  - The accumulator clears.
  - If a pop occurs in the same cycle, that byte goes to lane 0 of the new word and `idx`=1. This includes the case where WBYTES lanes then complete immediately, which is impossible for WBYTES≥2.
  - State returns to FILL.
- **Reset (`rrst`=1 at a `rclk` edge), including mid-word or mid-HOLD:**
  - State=FILL, `idx`=0.
  - `out_data`=0, `out_nbytes`=0, `out_valid`=0, `word_cnt`=0.
  - Partial or held data is discarded.
  - `rinc`=0 during reset, so no FIFO bytes are lost to reset.

## Timing
- Word latency: `out_valid` rises on the `rclk` edge after the pop of the final lane (or after the flush cycle), i.e. 1 cycle.
- Sustained throughput: WBYTES bytes per WBYTES cycles when the FIFO is non-empty and `out_ready`=1. There is no bubble at word boundaries.
- Backpressure: while HOLD persists with `out_ready`=0, `rinc`=0 and the FIFO fills.
- `out_ready` with `out_valid`=0 has no effect.
- `word_cnt` updates on the edge that completes the transfer.

## Test plan
1. **Reset values:** `rrst`=1 for 2 cycles with `rempty`=0 → `rinc`=0 throughout, and all outputs 0 afterwards.
2. **Streaming:** FIFO preloaded with 0x11,0x22,…,0x88, `out_ready`=1 → two words, 0x44332211 then 0x88776655, both with `out_nbytes`=4.
   - `rinc` stays high for 8 consecutive cycles.
   - `word_cnt`=2.
3. **Backpressure:** with `out_ready`=0 and 8 bytes queued → first word held stable, `rinc`=0 after the 4th pop.
   - Raising `out_ready` for 1 cycle transfers the word and pops 0x55 in the same cycle.
4. **Flush timing:**
   - 0xA1,0xB2 popped, then `flush` → `out_data`=0x0000B2A1, `out_nbytes`=2.
   - `flush` in the same cycle as the 3rd pop (0xC3) → 0x00C3B2A1, `out_nbytes`=3.
   - `flush` with `idx`=0 and `rempty`=1 → no output.
5. **Mid-operation reset:**
   - `rrst` after 3 of 4 bytes → no word is emitted; the next 4 bytes form a clean word starting at lane 0.
   - `rrst` in HOLD → `out_valid` drops on the next edge.
6. **Counter wrap:** preset by 65536 transfers, or forced → `word_cnt` wraps 0xFFFF→0x0000.

Source files
------------

// File: rtl/fifo1_rd_packer.sv
`default_nettype none
// ============================================================================
// Module   : fifo1_rd_packer
// Purpose  : Drains bytes from the fifo1 read port and packs them
//            little-endian into WBYTES-lane words on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module fifo1_rd_packer #(
  parameter int DSIZE  = 8,
  parameter int WBYTES = 4
) (
  input  logic                      rclk,
  input  logic                      rrst,
  input  logic [DSIZE-1:0]          rdata,
  input  logic                      rempty,
  output logic                      rinc,
  input  logic                      flush,
  output logic [DSIZE*WBYTES-1:0]   out_data,
  output logic [$clog2(WBYTES):0]   out_nbytes,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [15:0]               word_cnt
);

  localparam int IW = $clog2(WBYTES);
  localparam int NW = IW + 1;
  localparam logic [IW-1:0] c_last_idx = IW'(WBYTES - 1);
  localparam logic [NW-1:0] c_full_nb  = NW'(WBYTES);

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t                    r_state, w_state_next;
  logic [IW-1:0]             r_idx, w_idx_next;
  logic [DSIZE*WBYTES-1:0]   r_acc, w_acc_next;
  logic [NW-1:0]             r_nbytes, w_nbytes_next;
  logic [15:0]               r_word_cnt, w_word_cnt_next;
  logic                      w_pop;

  // A held word blocks popping unless it is leaving this same cycle.
  assign w_pop = !rrst && !rempty && (r_state == S_FILL || out_ready);
  assign rinc  = w_pop;

  always_comb begin
    w_state_next    = r_state;
    w_idx_next      = r_idx;
    w_acc_next      = r_acc;
    w_nbytes_next   = r_nbytes;
    w_word_cnt_next = r_word_cnt;
    case (r_state)
      S_FILL: begin
        if (w_pop) begin
          w_acc_next[r_idx*DSIZE +: DSIZE] = rdata;
          if (r_idx == c_last_idx) begin
            w_state_next  = S_HOLD;
            w_nbytes_next = c_full_nb;
            w_idx_next    = '0;
          end else if (flush) begin
            w_state_next  = S_HOLD;
            w_nbytes_next = {1'b0, r_idx} + NW'(1);
            w_idx_next    = '0;
          end else begin
            w_idx_next = r_idx + IW'(1);
          end
        end else if (flush && r_idx != '0) begin
          w_state_next  = S_HOLD;
          w_nbytes_next = {1'b0, r_idx};
          w_idx_next    = '0;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_word_cnt_next = r_word_cnt + 16'd1;
          w_acc_next      = '0;
          w_nbytes_next   = '0;
          w_idx_next      = '0;
          w_state_next    = S_FILL;
          // Back-to-back: the byte popped during the transfer starts the next word.
          if (w_pop) begin
            w_acc_next[DSIZE-1:0] = rdata;
            w_idx_next            = IW'(1);
          end
        end
      end
      default: w_state_next = S_FILL;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_state    <= S_FILL;
      r_idx      <= '0;
      r_acc      <= '0;
      r_nbytes   <= '0;
      r_word_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_idx      <= w_idx_next;
      r_acc      <= w_acc_next;
      r_nbytes   <= w_nbytes_next;
      r_word_cnt <= w_word_cnt_next;
    end
  end

  assign out_data   = r_acc;
  assign out_nbytes = r_nbytes;
  assign out_valid  = (r_state == S_HOLD);
  assign word_cnt   = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fifo1_rd_packer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fifo1_rd_packer
// Purpose  : Directed scoreboard bench for fifo1_rd_packer with a FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo1_rd_packer;

  localparam int DSIZE  = 8;
  localparam int WBYTES = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  nb;
  } exp_t;

  logic        rclk = 1'b0;
  logic        rrst;
  logic [7:0]  rdata;
  logic        rempty;
  logic        rinc;
  logic        flush;
  logic [31:0] out_data;
  logic [2:0]  out_nbytes;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] word_cnt;

  logic [7:0]  fifo_q[$];
  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic        last_pop;

  fifo1_rd_packer #(.DSIZE(DSIZE), .WBYTES(WBYTES)) dut (
    .rclk(rclk), .rrst(rrst), .rdata(rdata), .rempty(rempty), .rinc(rinc),
    .flush(flush), .out_data(out_data), .out_nbytes(out_nbytes),
    .out_valid(out_valid), .out_ready(out_ready), .word_cnt(word_cnt)
  );

  always #5 rclk = ~rclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fifo_upd();
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? 8'h00 : fifo_q[0];
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_upd();
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [2:0] n);
    exp_t e;
    e.data = d;
    e.nb   = n;
    sb.push_back(e);
  endtask

  // One clock: rinc is sampled mid-cycle, the model pops after the edge.
  task automatic cycle();
    logic p;
    @(negedge rclk);
    p = rinc;
    @(posedge rclk);
    #1;
    last_pop = p;
    if (p && fifo_q.size() > 0) void'(fifo_q.pop_front());
    fifo_upd();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Monitor: every accepted word is compared against the scoreboard head.
  always @(negedge rclk) begin
    if (rrst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word: got data 0x%0h nbytes %0d, expected none", out_data, out_nbytes);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("word_data", out_data, e.data);
        check("word_nbytes", {29'd0, out_nbytes}, {29'd0, e.nb});
      end
    end
  end

  initial begin
    rrst = 1'b1; flush = 1'b0; out_ready = 1'b0; last_pop = 1'b0;
    fifo_upd();

    // Reset with a non-empty FIFO: nothing may be popped.
    push(8'hEE);
    cycle(); check("rst_rinc0", {31'd0, last_pop}, 32'd0);
    cycle(); check("rst_rinc1", {31'd0, last_pop}, 32'd0);
    check("rst_valid",  {31'd0, out_valid}, 32'd0);
    check("rst_data",   out_data, 32'd0);
    check("rst_nbytes", {29'd0, out_nbytes}, 32'd0);
    check("rst_cnt",    {16'd0, word_cnt}, 32'd0);
    check("rst_fifo",   fifo_q.size(), 32'd1);
    fifo_q.delete(); fifo_upd();
    rrst = 1'b0;

    // Streaming with no bubble at the word boundary.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(8'(i * 8'h11));
    expect_word(32'h44332211, 3'd4);
    expect_word(32'h88776655, 3'd4);
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("stream_rinc", {31'd0, last_pop}, 32'd1);
    end
    cycles(2);
    check("stream_cnt", {16'd0, word_cnt}, 32'd2);

    // Backpressure: word held stable, FIFO stops draining.
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i * 8'h11));
    cycles(5);
    check("bp_valid", {31'd0, out_valid}, 32'd1);
    check("bp_data",  out_data, 32'h44332211);
    check("bp_rinc",  {31'd0, last_pop}, 32'd0);
    cycle();
    check("bp_hold_data", out_data, 32'h44332211);
    check("bp_hold_nb",   {29'd0, out_nbytes}, 32'd4);
    check("bp_fifo",      fifo_q.size(), 32'd4);
    expect_word(32'h44332211, 3'd4);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    check("bp_xfer_pop",  {31'd0, last_pop}, 32'd1);
    check("bp_xfer_fifo", fifo_q.size(), 32'd3);
    check("bp_lane0",     out_data, 32'h00000055);
    check("bp_cnt",       {16'd0, word_cnt}, 32'd3);
    cycles(4);
    check("bp_data2", out_data, 32'h88776655);
    expect_word(32'h88776655, 3'd4);
    out_ready = 1'b1;
    cycles(2);
    check("bp_cnt2", {16'd0, word_cnt}, 32'd4);

    // Flush after two pops, then one cycle of word latency.
    push(8'hA1); push(8'hB2);
    cycles(2);
    flush = 1'b1;
    expect_word(32'h0000B2A1, 3'd2);
    cycle();
    flush = 1'b0;
    check("flush2_valid", {31'd0, out_valid}, 32'd1);
    cycles(2);
    // Flush coinciding with the third pop.
    push(8'hA1); push(8'hB2); push(8'hC3);
    cycles(2);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    expect_word(32'h00C3B2A1, 3'd3);
    cycles(2);
    // Flush coinciding with the completing pop yields a full word.
    push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
    cycles(3);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    expect_word(32'hD4D3D2D1, 3'd4);
    cycles(2);
    // Flush with nothing accumulated and an empty FIFO is ignored.
    flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("flush_empty_valid", {31'd0, out_valid}, 32'd0);
    end
    flush = 1'b0;
    check("flush_cnt", {16'd0, word_cnt}, 32'd7);

    // Reset mid-word discards the partial word.
    push(8'h01); push(8'h02); push(8'h03);
    cycles(3);
    rrst = 1'b1;
    cycle();
    check("midrst_rinc", {31'd0, last_pop}, 32'd0);
    rrst = 1'b0;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_data",  out_data, 32'd0);
    check("midrst_cnt",   {16'd0, word_cnt}, 32'd0);
    push(8'h04); push(8'h05); push(8'h06); push(8'h07);
    expect_word(32'h07060504, 3'd4);
    cycles(6);
    check("midrst_cnt2", {16'd0, word_cnt}, 32'd1);

    // Reset while holding a word.
    out_ready = 1'b0;
    push(8'h0A); push(8'h0B); push(8'h0C); push(8'h0D);
    cycles(5);
    check("holdrst_pre", {31'd0, out_valid}, 32'd1);
    rrst = 1'b1;
    cycle();
    rrst = 1'b0;
    check("holdrst_valid", {31'd0, out_valid}, 32'd0);
    check("holdrst_nb",    {29'd0, out_nbytes}, 32'd0);

    // Counter wrap from a forced 0xFFFF.
    force dut.r_word_cnt = 16'hFFFF;
    #1;
    release dut.r_word_cnt;
    check("wrap_pre", {16'd0, word_cnt}, 32'h0000FFFF);
    push(8'hE1); push(8'hE2); push(8'hE3); push(8'hE4);
    expect_word(32'hE4E3E2E1, 3'd4);
    out_ready = 1'b1;
    cycles(6);
    check("wrap_cnt", {16'd0, word_cnt}, 32'd0);

    check("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
